// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_seq_pkg;

  // Fetch control states: IDLE after reset, REQ while presenting an address,
  // WAIT for the memory response, HOLD while the hazard unit stalls.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP              = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: synchronous reset to RESET_VECTOR, load-enabled.
module fetch_pc_reg
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        i_clk_w,
  input  logic        i_rst_w,
  input  logic        i_load_w,
  input  logic [31:0] i_pc_d_w,
  output logic [31:0] o_pc_q_w
);

  logic [31:0] pc_q;

  // PC holds its value unless the sequencer commits a new fetch address.
  always_ff @(posedge i_clk_w) begin
    if (i_rst_w) begin
      pc_q <= RESET_VECTOR;
    end else if (i_load_w) begin
      pc_q <= i_pc_d_w;
    end
  end

  assign o_pc_q_w = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: request/response handshake with instruction
// memory, stall handling, pending branch redirect and delivered-instruction
// counter. Optional feature macro: FETCH_SEQ_ALIGN_CHECK_EN adds the sticky
// o_misalign_w output and forces redirect targets to word alignment.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        i_clk_w,
  input  logic        i_rst_w,
  output logic        o_imem_req_w,
  input  logic        i_imem_ready_w,
  output logic [31:0] o_imem_addr_w,
  input  logic        i_imem_valid_w,
  input  logic        i_stall_w,
  input  logic        i_branch_w,
  input  logic [31:0] i_branch_target_w,
  output logic [31:0] o_pc_w,
  output logic [31:0] o_pc_plus4_w,
  output logic        o_instr_valid_w,
  output logic [31:0] o_fetch_cnt_w
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
  ,
  output logic        o_misalign_w
`endif
);

  // Redirect targets are word-aligned when the alignment check is built in;
  // otherwise they pass through untouched.
  function automatic logic [31:0] align_target(input logic [31:0] tgt);
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
    return {tgt[31:2], 2'b00};
`else
    return tgt;
`endif
  endfunction

  fetch_state_e state_q, state_d;
  logic         pend_vld_q, pend_vld_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic         pc_load;
  logic         req;
  logic         instr_vld;
  logic         sel_tgt;
  logic [31:0]  raw_tgt;

  fetch_pc_reg #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .i_clk_w  (i_clk_w),
    .i_rst_w  (i_rst_w),
    .i_load_w (pc_load),
    .i_pc_d_w (pc_d),
    .o_pc_q_w (pc_q)
  );

  // Next-PC select: a same-cycle branch beats an older pending redirect,
  // which beats sequential PC+4 (wraps naturally at 2^32).
  always_comb begin
    sel_tgt = i_branch_w | pend_vld_q;
    raw_tgt = i_branch_w ? i_branch_target_w : pend_tgt_q;
    pc_d    = sel_tgt ? align_target(raw_tgt) : (pc_q + PC_STEP);
  end

  // Fetch FSM next-state, handshake outputs, counter and redirect capture.
  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    cnt_d      = cnt_q;
    pc_load    = 1'b0;
    req        = 1'b0;
    instr_vld  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        req = 1'b1;
        if (i_imem_ready_w) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Responses are only meaningful here; elsewhere the strobe is ignored.
        if (i_imem_valid_w) begin
          instr_vld = 1'b1;
          cnt_d     = cnt_q + 32'd1;
          if (i_stall_w) begin
            state_d = ST_HOLD;
          end else begin
            pc_load = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (!i_stall_w) begin
          pc_load = 1'b1;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A PC update consumes any redirect (including one arriving this cycle);
    // otherwise the newest branch target overwrites the pending one.
    if (pc_load) begin
      pend_vld_d = 1'b0;
    end else if (i_branch_w) begin
      pend_vld_d = 1'b1;
      pend_tgt_d = i_branch_target_w;
    end
  end

  // Control state: FSM, redirect-pending flag and delivered counter.
  always_ff @(posedge i_clk_w) begin
    if (i_rst_w) begin
      state_q    <= ST_IDLE;
      pend_vld_q <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  // Redirect target payload; only meaningful while pend_vld_q is set.
  always_ff @(posedge i_clk_w) begin
    pend_tgt_q <= pend_tgt_d;
  end

`ifdef FETCH_SEQ_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // Sticky flag: any committed redirect target with non-zero low bits.
  always_comb begin
    misalign_d = misalign_q | (pc_load & sel_tgt & (raw_tgt[1:0] != 2'b00));
  end

  // Misalign flag register, cleared only by reset.
  always_ff @(posedge i_clk_w) begin
    if (i_rst_w) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign o_misalign_w = misalign_q;
`endif

  // Handshake strobes are masked while reset is asserted so no transfer is
  // signalled in the cycle reset arrives.
  assign o_imem_req_w    = req & ~i_rst_w;
  assign o_instr_valid_w = instr_vld & ~i_rst_w;
  assign o_imem_addr_w   = pc_q;
  assign o_pc_w          = pc_q;
  assign o_pc_plus4_w    = pc_q + PC_STEP;
  assign o_fetch_cnt_w   = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with constant
// expectations plus a randomized run checked against a transaction-level model.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;

  localparam int PH_IDLE = 0;
  localparam int PH_ASK  = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_HOLD = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        valid = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = 32'd0;
  logic        o_req;
  logic [31:0] o_addr;
  logic [31:0] o_pc;
  logic [31:0] o_pc4;
  logic        o_iv;
  logic [31:0] o_cnt;
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
  logic        o_mis;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_ph;
  logic [31:0] m_pc;
  logic [31:0] m_ptgt;
  logic [31:0] m_cnt;
  bit          m_pend;
  bit          m_mis;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_VECTOR (RV)
  ) dut (
    .i_clk_w           (clk),
    .i_rst_w           (rst),
    .o_imem_req_w      (o_req),
    .i_imem_ready_w    (ready),
    .o_imem_addr_w     (o_addr),
    .i_imem_valid_w    (valid),
    .i_stall_w         (stall),
    .i_branch_w        (br),
    .i_branch_target_w (tgt),
    .o_pc_w            (o_pc),
    .o_pc_plus4_w      (o_pc4),
    .o_instr_valid_w   (o_iv),
    .o_fetch_cnt_w     (o_cnt)
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
    ,
    .o_misalign_w      (o_mis)
`endif
  );

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_clock();
    bit          adv;
    logic [31:0] nxt;
    adv = 0;
    if (rst) begin
      m_ph = PH_IDLE; m_pc = RV; m_pend = 0; m_cnt = 0; m_mis = 0;
      return;
    end
    case (m_ph)
      PH_IDLE: m_ph = PH_ASK;
      PH_ASK:  if (ready) m_ph = PH_WAIT;
      PH_WAIT: if (valid) begin
        m_cnt = m_cnt + 1;
        if (stall) m_ph = PH_HOLD;
        else begin adv = 1; m_ph = PH_ASK; end
      end
      default: if (!stall) begin adv = 1; m_ph = PH_ASK; end
    endcase
    if (adv) begin
      if (br) nxt = tgt;
      else if (m_pend) nxt = m_ptgt;
      else nxt = m_pc + 32'd4;
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
      if ((br || m_pend) && nxt[1:0] != 2'b00) begin
        m_mis = 1;
        nxt[1:0] = 2'b00;
      end
`endif
      m_pc = nxt;
      m_pend = 0;
    end else if (br) begin
      m_pend = 1;
      m_ptgt = tgt;
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic reset_dut();
    rst = 1; ready = 0; valid = 0; stall = 0; br = 0; tgt = 0;
    clk_step();
    rst = 0;
  endtask

  // From IDLE, complete n zero-wait fetches; ends in the request phase.
  task automatic run_deliveries(input int n);
    ready = 1; valid = 1; stall = 0; br = 0;
    clk_step();
    for (int i = 0; i < n; i++) begin
      clk_step();
      clk_step();
    end
  endtask

  task automatic test_reset();
    rst = 1; ready = 1; valid = 1;
    clk_step();
    clk_step();
    #2;
    n_vec++;
    if (o_req !== 1'b0 || o_iv !== 1'b0) begin
      n_err++; $display("FAIL reset_strobes got req=%b iv=%b want 0 0", o_req, o_iv);
    end
    n_vec++;
    if (o_pc !== RV || o_pc4 !== RV + 32'd4 || o_cnt !== 32'd0) begin
      n_err++; $display("FAIL reset_regs got pc=%h pc4=%h cnt=%0d want %h %h 0", o_pc, o_pc4, o_cnt, RV, RV + 32'd4);
    end
    rst = 0;
    #2;
    n_vec++;
    if (o_req !== 1'b0 || o_iv !== 1'b0 || o_pc !== RV || o_cnt !== 32'd0) begin
      n_err++; $display("FAIL reset_after got req=%b iv=%b pc=%h cnt=%0d want 0 0 %h 0", o_req, o_iv, o_pc, o_cnt, RV);
    end
    clk_step();
    #2;
    n_vec++;
    if (o_req !== 1'b1) begin
      n_err++; $display("FAIL reset_first_req got %b want 1", o_req);
    end
  endtask

  task automatic test_stream();
    reset_dut();
    ready = 1; valid = 1;
    clk_step();
    for (int k = 0; k < 4; k++) begin
      #2;
      n_vec++;
      if (o_req !== 1'b1 || o_addr !== 32'(4 * k) || o_iv !== 1'b0) begin
        n_err++; $display("FAIL stream_req k=%0d got req=%b addr=%h iv=%b want 1 %h 0", k, o_req, o_addr, o_iv, 32'(4 * k));
      end
      clk_step();
      #2;
      n_vec++;
      if (o_iv !== 1'b1 || o_pc !== 32'(4 * k) || o_req !== 1'b0) begin
        n_err++; $display("FAIL stream_deliver k=%0d got iv=%b pc=%h req=%b want 1 %h 0", k, o_iv, o_pc, o_req, 32'(4 * k));
      end
      clk_step();
    end
    #2;
    n_vec++;
    if (o_cnt !== 32'd4 || o_pc !== 32'h10) begin
      n_err++; $display("FAIL stream_count got cnt=%0d pc=%h want 4 00000010", o_cnt, o_pc);
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    run_deliveries(2);
    ready = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_vec++;
      if (o_req !== 1'b1 || o_addr !== 32'h8 || o_pc !== 32'h8) begin
        n_err++; $display("FAIL backpressure c=%0d got req=%b addr=%h pc=%h want 1 8 8", c, o_req, o_addr, o_pc);
      end
      clk_step();
    end
    ready = 1; valid = 0;
    clk_step();
    valid = 1;
    #2;
    n_vec++;
    if (o_iv !== 1'b1 || o_pc !== 32'h8 || o_cnt !== 32'd2) begin
      n_err++; $display("FAIL backpressure_deliver got iv=%b pc=%h cnt=%0d want 1 8 2", o_iv, o_pc, o_cnt);
    end
    clk_step();
  endtask

  task automatic test_stall();
    reset_dut();
    run_deliveries(4);
    ready = 1; valid = 0;
    clk_step();
    valid = 1; stall = 1;
    #2;
    n_vec++;
    if (o_iv !== 1'b1 || o_pc !== 32'h10) begin
      n_err++; $display("FAIL stall_deliver got iv=%b pc=%h want 1 10", o_iv, o_pc);
    end
    clk_step();
    #2;
    n_vec++;
    if (o_req !== 1'b0 || o_iv !== 1'b0 || o_pc !== 32'h10) begin
      n_err++; $display("FAIL stall_hold1 got req=%b iv=%b pc=%h want 0 0 10", o_req, o_iv, o_pc);
    end
    clk_step();
    stall = 0; valid = 0;
    #2;
    n_vec++;
    if (o_req !== 1'b0 || o_pc !== 32'h10) begin
      n_err++; $display("FAIL stall_hold2 got req=%b pc=%h want 0 10", o_req, o_pc);
    end
    clk_step();
    #2;
    n_vec++;
    if (o_req !== 1'b1 || o_addr !== 32'h14 || o_cnt !== 32'd5) begin
      n_err++; $display("FAIL stall_resume got req=%b addr=%h cnt=%0d want 1 14 5", o_req, o_addr, o_cnt);
    end
  endtask

  task automatic test_branch_newest();
    reset_dut();
    run_deliveries(8);
    ready = 1; valid = 0;
    clk_step();
    br = 1; tgt = 32'h100;
    clk_step();
    tgt = 32'h200;
    clk_step();
    br = 0; valid = 1;
    #2;
    n_vec++;
    if (o_iv !== 1'b1 || o_pc !== 32'h20) begin
      n_err++; $display("FAIL branch_deliver got iv=%b pc=%h want 1 20", o_iv, o_pc);
    end
    clk_step();
    #2;
    n_vec++;
    if (o_req !== 1'b1 || o_addr !== 32'h200 || o_pc4 !== 32'h204) begin
      n_err++; $display("FAIL branch_newest got req=%b addr=%h pc4=%h want 1 200 204", o_req, o_addr, o_pc4);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    run_deliveries(6);
    ready = 1; valid = 0;
    clk_step();
    valid = 1; br = 1; tgt = 32'h40;
    clk_step();
    br = 0; valid = 0;
    clk_step();
    #2;
    n_vec++;
    if (o_pc !== 32'h40 || o_cnt !== 32'd7 || o_req !== 1'b0) begin
      n_err++; $display("FAIL resetmid_setup got pc=%h cnt=%0d req=%b want 40 7 0", o_pc, o_cnt, o_req);
    end
    rst = 1;
    clk_step();
    rst = 0; valid = 1;
    #2;
    n_vec++;
    if (o_req !== 1'b0 || o_iv !== 1'b0 || o_pc !== RV || o_pc4 !== RV + 32'd4 || o_cnt !== 32'd0) begin
      n_err++; $display("FAIL resetmid_idle got req=%b iv=%b pc=%h pc4=%h cnt=%0d want 0 0 %h %h 0", o_req, o_iv, o_pc, o_pc4, o_cnt, RV, RV + 32'd4);
    end
    ready = 0;
    clk_step();
    #2;
    n_vec++;
    if (o_req !== 1'b1 || o_iv !== 1'b0 || o_cnt !== 32'd0) begin
      n_err++; $display("FAIL resetmid_late_valid got req=%b iv=%b cnt=%0d want 1 0 0", o_req, o_iv, o_cnt);
    end
    clk_step();
    #2;
    n_vec++;
    if (o_cnt !== 32'd0) begin
      n_err++; $display("FAIL resetmid_cnt got %0d want 0", o_cnt);
    end
  endtask

  task automatic test_pc_wrap();
    reset_dut();
    run_deliveries(1);
    ready = 1; valid = 0;
    clk_step();
    valid = 1; br = 1; tgt = 32'hFFFF_FFFC;
    clk_step();
    br = 0; valid = 0;
    #2;
    n_vec++;
    if (o_addr !== 32'hFFFF_FFFC || o_pc4 !== 32'h0000_0000) begin
      n_err++; $display("FAIL pcwrap_top got addr=%h pc4=%h want fffffffc 00000000", o_addr, o_pc4);
    end
    clk_step();
    valid = 1;
    clk_step();
    valid = 0;
    #2;
    n_vec++;
    if (o_pc !== 32'h0 || o_pc4 !== 32'h4) begin
      n_err++; $display("FAIL pcwrap_zero got pc=%h pc4=%h want 0 4", o_pc, o_pc4);
    end
  endtask

`ifdef FETCH_SEQ_ALIGN_CHECK_EN
  task automatic test_misalign();
    reset_dut();
    run_deliveries(1);
    ready = 1; valid = 0;
    clk_step();
    valid = 1; br = 1; tgt = 32'h103;
    clk_step();
    br = 0; valid = 0;
    #2;
    n_vec++;
    if (o_addr !== 32'h100 || o_mis !== 1'b1) begin
      n_err++; $display("FAIL misalign_set got addr=%h mis=%b want 100 1", o_addr, o_mis);
    end
    run_deliveries(0);
    clk_step();
    clk_step();
    #2;
    n_vec++;
    if (o_mis !== 1'b1) begin
      n_err++; $display("FAIL misalign_sticky got %b want 1", o_mis);
    end
    rst = 1;
    clk_step();
    rst = 0;
    #2;
    n_vec++;
    if (o_mis !== 1'b0) begin
      n_err++; $display("FAIL misalign_clear got %b want 0", o_mis);
    end
  endtask
`endif

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      ready = ($urandom_range(0, 3) != 0);
      valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 7) == 0);
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
      tgt   = $urandom;
`else
      tgt   = $urandom & 32'hFFFF_FFFC;
`endif
      if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFFC;
      #2;
      n_vec++;
      if (o_req !== (m_ph == PH_ASK && !rst) ||
          o_iv !== (m_ph == PH_WAIT && valid && !rst)) begin
        n_err++; $display("FAIL random_strobes i=%0d got req=%b iv=%b want %b %b", i, o_req, o_iv,
                          (m_ph == PH_ASK && !rst), (m_ph == PH_WAIT && valid && !rst));
      end
      n_vec++;
      if (o_pc !== m_pc || o_addr !== m_pc || o_pc4 !== m_pc + 32'd4 || o_cnt !== m_cnt) begin
        n_err++; $display("FAIL random_regs i=%0d got pc=%h addr=%h pc4=%h cnt=%0d want %h %h %h %0d", i,
                          o_pc, o_addr, o_pc4, o_cnt, m_pc, m_pc, m_pc + 32'd4, m_cnt);
      end
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
      n_vec++;
      if (o_mis !== m_mis) begin
        n_err++; $display("FAIL random_misalign i=%0d got %b want %b", i, o_mis, m_mis);
      end
`endif
      clk_step();
    end
    rst = 0; br = 0;
  endtask

  initial begin
    m_ph = PH_IDLE; m_pc = RV; m_ptgt = 0; m_cnt = 0; m_pend = 0; m_mis = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_branch_newest();
    test_reset_mid();
    test_pc_wrap();
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
